// File: rtl/rc_car_motion_ctrl.sv
// rc_car_motion_ctrl: turns decoded UART command bytes into a registered drive
// state. Per-direction obstacle sensors are debounced, and motion toward a
// detected obstacle is blocked. Includes a command watchdog and timed turns
// that return to the heading held before the turn.
module rc_car_motion_ctrl #(
  parameter logic [7:0] CMD_UP    = 8'h71,
  parameter logic [7:0] CMD_DOWN  = 8'h77,
  parameter logic [7:0] CMD_LEFT  = 8'h65,
  parameter logic [7:0] CMD_RIGHT = 8'h72,
  parameter logic [7:0] CMD_ESTOP = 8'h74,
  parameter int         DEBOUNCE  = 4,
  parameter int         TIMEOUT   = 1000,
  parameter int         TURN_LEN  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  input  logic [1:0] obst,
  output logic [2:0] state,
  output logic       is_crush,
  output logic [1:0] crush_dir,
  output logic       cmd_reject,
  output logic       timeout_stop
);

  localparam int WD_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TC_W      = (TURN_LEN > 0) ? $clog2(TURN_LEN + 1) : 1;
  localparam int WD_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int TURN_LAST = (TURN_LEN > 0) ? TURN_LEN - 1 : 0;
  localparam logic [7:0] DEB_MAX = 8'(DEBOUNCE);

  typedef enum logic [2:0] {
    S_STOP  = 3'b000,
    S_FWD   = 3'b001,
    S_BWD   = 3'b010,
    S_LEFT  = 3'b011,
    S_RIGHT = 3'b100
  } drive_e;

  drive_e            state_q, state_d;
  drive_e            saved_q, saved_d;
  logic [7:0]        deb_cnt_q [2];
  logic [7:0]        deb_cnt_d [2];
  logic [1:0]        dir_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [TC_W-1:0]   tc_q, tc_d;
  logic              reject_d, tstop_d, turn_start;

  logic cmd_up, cmd_dn, cmd_left, cmd_right, cmd_stop;
  logic up_ok, dn_ok, accepted, refuse;
  logic is_turn, legal, crash_stop, wd_fire, turn_exp;

  assign state = state_q;

  // Command decode and per-edge event conditions
  assign cmd_up     = cmd_valid && (cmd_data == CMD_UP);
  assign cmd_dn     = cmd_valid && (cmd_data == CMD_DOWN);
  assign cmd_left   = cmd_valid && (cmd_data == CMD_LEFT);
  assign cmd_right  = cmd_valid && (cmd_data == CMD_RIGHT);
  assign cmd_stop   = cmd_valid && (cmd_data == CMD_ESTOP);
  assign up_ok      = cmd_up && !crush_dir[0];
  assign dn_ok      = cmd_dn && !crush_dir[1];
  assign refuse     = (cmd_up && crush_dir[0]) || (cmd_dn && crush_dir[1]);
  assign accepted   = cmd_stop || up_ok || dn_ok || cmd_left || cmd_right;
  assign is_turn    = (state_q == S_LEFT) || (state_q == S_RIGHT);
  assign legal      = (state_q == S_STOP) || (state_q == S_FWD) ||
                      (state_q == S_BWD) || is_turn;
  assign crash_stop = ((state_q == S_FWD) && crush_dir[0]) ||
                      ((state_q == S_BWD) && crush_dir[1]);
  assign wd_fire    = (TIMEOUT != 0) && (state_q != S_STOP) &&
                      (wd_q == WD_W'(WD_LAST));
  assign turn_exp   = (TURN_LEN != 0) && is_turn && (tc_q == TC_W'(TURN_LAST));

  // Debounce next-state: count consecutive high samples, flag at DEBOUNCE
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = 8'd0;
      dir_d[i]     = 1'b0;
      if (obst[i]) begin
        deb_cnt_d[i] = (deb_cnt_q[i] == DEB_MAX) ? deb_cnt_q[i] : deb_cnt_q[i] + 8'd1;
        dir_d[i]     = crush_dir[i] || ((deb_cnt_q[i] + 8'd1) >= DEB_MAX);
      end
    end
  end

  // Drive FSM next-state with ESTOP > crash > watchdog > command > turn expiry
  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    tstop_d    = 1'b0;
    turn_start = 1'b0;
    reject_d   = refuse;
    if (!legal) begin
      state_d = S_STOP;
    end else if (cmd_stop || crash_stop) begin
      state_d = S_STOP;
    end else if (wd_fire) begin
      state_d = S_STOP;
      tstop_d = 1'b1;
    end else if (up_ok) begin
      state_d = S_FWD;
    end else if (dn_ok) begin
      state_d = S_BWD;
    end else if (cmd_left || cmd_right) begin
      state_d    = cmd_left ? S_LEFT : S_RIGHT;
      turn_start = 1'b1;
      if ((state_q == S_FWD) || (state_q == S_BWD)) saved_d = state_q;
      else if (!is_turn)                            saved_d = S_STOP;
    end else if (turn_exp) begin
      if (((saved_q == S_FWD) && crush_dir[0]) || ((saved_q == S_BWD) && crush_dir[1]))
        state_d = S_STOP;
      else
        state_d = saved_q;
    end
  end

  // Watchdog and turn counter next values
  always_comb begin
    wd_d = wd_q + WD_W'(1);
    if (accepted || (state_q == S_STOP) || wd_fire || (TIMEOUT == 0)) wd_d = '0;
    tc_d = tc_q;
    if (turn_start)                                tc_d = '0;
    else if (is_turn && (tc_q != TC_W'(TURN_LAST))) tc_d = tc_q + TC_W'(1);
  end

  // State, flags, counters and output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_STOP;
      saved_q      <= S_STOP;
      deb_cnt_q[0] <= 8'd0;
      deb_cnt_q[1] <= 8'd0;
      crush_dir    <= 2'b00;
      is_crush     <= 1'b0;
      wd_q         <= '0;
      tc_q         <= '0;
      cmd_reject   <= 1'b0;
      timeout_stop <= 1'b0;
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
      crush_dir    <= dir_d;
      is_crush     <= |dir_d;
      wd_q         <= wd_d;
      tc_q         <= tc_d;
      cmd_reject   <= reject_d;
      timeout_stop <= tstop_d;
    end
  end

endmodule

// File: tb/tb_rc_car_motion_ctrl.sv
// Directed bench for rc_car_motion_ctrl with DEBOUNCE=2, TIMEOUT=20, TURN_LEN=5.
module tb_rc_car_motion_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic [1:0] obst;
  logic [2:0] state;
  logic       is_crush;
  logic [1:0] crush_dir;
  logic       cmd_reject;
  logic       timeout_stop;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [1:0] cd;
    logic       rj;
    logic       ts;
  } exp_t;

  exp_t sb[$];

  localparam logic [2:0] STOP = 3'b000, FWD = 3'b001, BWD = 3'b010,
                         LEFT = 3'b011, RIGHT = 3'b100;

  rc_car_motion_ctrl #(
    .DEBOUNCE (2),
    .TIMEOUT  (20),
    .TURN_LEN (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .obst         (obst),
    .state        (state),
    .is_crush     (is_crush),
    .crush_dir    (crush_dir),
    .cmd_reject   (cmd_reject),
    .timeout_stop (timeout_stop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench time limit reached");
  end

  task automatic chk(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp_v);
  endtask

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic cyc(input logic r, input logic [7:0] d, input logic v, input logic [1:0] o,
                     input string tag, input logic [2:0] st, input logic [1:0] cd,
                     input logic rj, input logic ts);
    exp_t e;
    rst       = r;
    cmd_data  = d;
    cmd_valid = v;
    obst      = o;
    e.tag = tag; e.st = st; e.cd = cd; e.rj = rj; e.ts = ts;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, "state",        {1'b0, state},     {1'b0, e.st});
    chk(e.tag, "crush_dir",    {2'b0, crush_dir}, {2'b0, e.cd});
    chk(e.tag, "is_crush",     {3'b0, is_crush},  {3'b0, |e.cd});
    chk(e.tag, "cmd_reject",   {3'b0, cmd_reject},   {3'b0, e.rj});
    chk(e.tag, "timeout_stop", {3'b0, timeout_stop}, {3'b0, e.ts});
  endtask

  task automatic cmd(input logic [7:0] d, input logic [1:0] o, input string tag,
                     input logic [2:0] st, input logic [1:0] cd, input logic rj);
    cyc(1'b0, d, 1'b1, o, tag, st, cd, rj, 1'b0);
  endtask

  task automatic idle(input logic [1:0] o, input string tag, input logic [2:0] st,
                      input logic [1:0] cd, input logic ts);
    cyc(1'b0, 8'h00, 1'b0, o, tag, st, cd, 1'b0, ts);
  endtask

  initial begin
    rst = 1'b1; cmd_data = 8'h00; cmd_valid = 1'b0; obst = 2'b00;

    // Reset and basic command decode
    cyc(1'b1, 8'h00, 1'b0, 2'b00, "reset", STOP, 2'b00, 1'b0, 1'b0);
    cmd(8'h71, 2'b00, "cmd_up",    FWD,  2'b00, 1'b0);
    cmd(8'h77, 2'b00, "cmd_down",  BWD,  2'b00, 1'b0);
    cmd(8'h74, 2'b00, "cmd_estop", STOP, 2'b00, 1'b0);
    cmd(8'h71, 2'b00, "cmd_up2",   FWD,  2'b00, 1'b0);
    cmd(8'h70, 2'b00, "cmd_bad",   FWD,  2'b00, 1'b0);

    // Front crash while moving forward, then refused/accepted commands
    idle(2'b01, "front_deb1", FWD,  2'b00, 1'b0);
    idle(2'b01, "front_deb2", FWD,  2'b01, 1'b0);
    idle(2'b01, "crash_stop", STOP, 2'b01, 1'b0);
    cmd(8'h71, 2'b01, "up_reject", STOP, 2'b01, 1'b1);
    idle(2'b01, "reject_end", STOP, 2'b01, 1'b0);
    cmd(8'h77, 2'b01, "down_ok",   BWD,  2'b01, 1'b0);
    idle(2'b00, "front_clr",  BWD,  2'b00, 1'b0);
    cmd(8'h74, 2'b00, "estop2",    STOP, 2'b00, 1'b0);

    // Timed left turn returns to forward heading
    cmd(8'h71, 2'b00, "t_up",   FWD,  2'b00, 1'b0);
    cmd(8'h65, 2'b00, "t_left", LEFT, 2'b00, 1'b0);
    for (int i = 1; i <= 4; i++) idle(2'b00, $sformatf("t_hold%0d", i), LEFT, 2'b00, 1'b0);
    idle(2'b00, "t_expire", FWD, 2'b00, 1'b0);
    cmd(8'h74, 2'b00, "t_estop", STOP, 2'b00, 1'b0);

    // Right turn from backward; rear obstacle appears, expiry goes to STOP
    cmd(8'h77, 2'b00, "r_down",  BWD,   2'b00, 1'b0);
    cmd(8'h72, 2'b00, "r_right", RIGHT, 2'b00, 1'b0);
    idle(2'b10, "r_deb1",  RIGHT, 2'b00, 1'b0);
    idle(2'b10, "r_deb2",  RIGHT, 2'b10, 1'b0);
    idle(2'b10, "r_hold3", RIGHT, 2'b10, 1'b0);
    idle(2'b10, "r_hold4", RIGHT, 2'b10, 1'b0);
    idle(2'b10, "r_expire_blocked", STOP, 2'b10, 1'b0);
    cmd(8'h77, 2'b10, "down_reject", STOP, 2'b10, 1'b1);
    idle(2'b00, "rear_clr", STOP, 2'b00, 1'b0);

    // Watchdog: 20 edges without a command
    cmd(8'h71, 2'b00, "w_up", FWD, 2'b00, 1'b0);
    for (int i = 1; i <= 19; i++) idle(2'b00, $sformatf("w_run%0d", i), FWD, 2'b00, 1'b0);
    idle(2'b00, "w_fire", STOP, 2'b00, 1'b1);
    idle(2'b00, "w_after", STOP, 2'b00, 1'b0);

    // Watchdog postponed by a command at edge 15
    cmd(8'h71, 2'b00, "p_up", FWD, 2'b00, 1'b0);
    for (int i = 1; i <= 14; i++) idle(2'b00, $sformatf("p_run%0d", i), FWD, 2'b00, 1'b0);
    cmd(8'h71, 2'b00, "p_refresh", FWD, 2'b00, 1'b0);
    for (int i = 16; i <= 34; i++) idle(2'b00, $sformatf("p_run%0d", i), FWD, 2'b00, 1'b0);
    idle(2'b00, "p_fire", STOP, 2'b00, 1'b1);
    idle(2'b00, "p_after", STOP, 2'b00, 1'b0);

    // Single-cycle glitch does not register a crash
    idle(2'b01, "glitch_hi", STOP, 2'b00, 1'b0);
    idle(2'b00, "glitch_lo", STOP, 2'b00, 1'b0);
    idle(2'b00, "glitch_lo2", STOP, 2'b00, 1'b0);

    // Left turn from STOP returns to STOP
    cmd(8'h65, 2'b00, "s_left", LEFT, 2'b00, 1'b0);
    for (int i = 1; i <= 4; i++) idle(2'b00, $sformatf("s_hold%0d", i), LEFT, 2'b00, 1'b0);
    idle(2'b00, "s_expire", STOP, 2'b00, 1'b0);

    // Reset mid-turn and mid-debounce clears everything
    cmd(8'h65, 2'b00, "x_left", LEFT, 2'b00, 1'b0);
    idle(2'b01, "x_deb1", LEFT, 2'b00, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 2'b01, "x_reset", STOP, 2'b00, 1'b0, 1'b0);
    idle(2'b01, "x_no_carry", STOP, 2'b00, 1'b0);
    idle(2'b00, "x_clr", STOP, 2'b00, 1'b0);
    for (int i = 1; i <= 5; i++) idle(2'b00, $sformatf("x_idle%0d", i), STOP, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rc_car_motion_ctrl.md
# rc_car_motion_ctrl

Parametrised motion-command state machine for the RC car. Turns decoded UART command bytes into a registered drive state, debounces per-direction obstacle sensors, and blocks motion toward a detected obstacle instead of freezing the car. Adds a command watchdog and timed turns that return to the prior heading. Sits between the UART receiver and the motor-drive/PWM stage.

## Interface
- CMD_UP, default 'h71, byte for FORWARD
- CMD_DOWN, default 'h77, byte for BACKWARD
- CMD_LEFT, default 'h65, byte for GO_LEFT
- CMD_RIGHT, default 'h72, byte for GO_RIGHT
- CMD_ESTOP, default 'h74, byte for STOP
- DEBOUNCE, default 4, consecutive high samples (1..255) before a sensor is treated as a crash
- TIMEOUT, default 1000, cycles without an accepted command before auto-STOP; 0 disables; counter width $clog2(TIMEOUT+1)
- TURN_LEN, default 50, cycles spent in a turn before returning to prior heading; 0 means turn holds until next command

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cmd_data  in  8  command byte
- cmd_valid  in  1  one-cycle strobe qualifying cmd_data
- obst  in  2  raw obstacle sensors; bit0 front, bit1 rear
- state  out  3  drive state: STOP 3'b000, FORWARD 3'b001, BACKWARD 3'b010, GO_LEFT 3'b011, GO_RIGHT 3'b100
- is_crush  out  1  OR of debounced crash flags
- crush_dir  out  2  debounced crash flags; bit0 front, bit1 rear
- cmd_reject  out  1  one-cycle pulse: valid command refused because of a crash
- timeout_stop  out  1  one-cycle pulse: watchdog forced STOP

## Operation
- Reset: state=STOP, is_crush=0, crush_dir=0, cmd_reject=0, timeout_stop=0; debounce, watchdog, turn counters=0; saved heading=STOP.
- Debounce, per channel: counter increments each cycle obst[i]=1, saturates at DEBOUNCE; crush_dir[i] sets when counter reaches DEBOUNCE; any cycle with obst[i]=0 clears counter and crush_dir[i] on that edge.
- Commands sampled only when cmd_valid=1. Bytes not matching a CMD_* parameter are ignored: no state change, no reject, no watchdog refresh.
- Accepted commands:
  - ESTOP -> STOP.
  - UP -> FORWARD, unless crush_dir[0]=1.
  - DOWN -> BACKWARD, unless crush_dir[1]=1.
  - LEFT/RIGHT -> GO_LEFT/GO_RIGHT. Saved heading is the current state if FORWARD/BACKWARD, else it is unchanged when already turning, else STOP. Turn counter clears.
- Refused UP/DOWN: cmd_reject=1 for one cycle; state unchanged; watchdog not refreshed.
- Crash stop: FORWARD with crush_dir[0]=1, or BACKWARD with crush_dir[1]=1 -> STOP. Turns are not crash-stopped.
- Turn expiry (TURN_LEN>0): after TURN_LEN cycles in GO_LEFT/GO_RIGHT, return to saved heading. If that heading is now blocked, go to STOP.
- Watchdog: counter clears on every accepted command and while state=STOP. Otherwise it increments. On reaching TIMEOUT: state -> STOP, timeout_stop pulses once.
- Per-edge priority: rst > ESTOP > crash stop > watchdog > other accepted command > turn expiry.
- Illegal state encodings (3'b101..3'b111) -> STOP on next edge.

## Timing
- All outputs registered. A command sampled at edge N is visible on state after edge N, a 1-cycle latency.
- Crash: obst rising before edge k. crush_dir/is_crush rise after edge k+DEBOUNCE-1. Crash STOP appears one edge later, because state reacts to the registered flag.
- A command and a crash in the same cycle follow priority. UP arriving while crush_dir[0]=1 is rejected. If the flag sets on the same edge as UP is accepted, the car goes FORWARD, then STOP next edge.
- Turn entered at edge N returns to heading at edge N+TURN_LEN.
- The watchdog counter counts edges since the last accepted command; STOP occurs on the edge the count hits TIMEOUT.
- rst asserted mid-turn or mid-debounce clears everything on that edge. There is no carry-over.

## Test plan
Bench parameters: DEBOUNCE=2, TIMEOUT=20, TURN_LEN=5.
- Reset, then cmd 'h71 -> state=001 next cycle. Then 'h77 -> 010. Then 'h74 -> 000. Then 'h70 -> state unchanged, no reject.
- FORWARD, obst=2'b01 held -> crush_dir=01 after 2nd edge, state=000 one edge later. Then 'h71 -> cmd_reject pulse, state=000. Then 'h77 -> 010 accepted.
- FORWARD, then 'h65 -> 011. Exactly 5 cycles later state=001 with no further command.
- BACKWARD, 'h72, obst=2'b10 raised during the turn -> at expiry state=000, not 010.
- FORWARD, no commands -> timeout_stop pulses and state=000 at the 20th edge. A valid command at edge 15 postpones STOP to edge 35.
- obst=2'b01 for 1 cycle, then 0 -> no crush. rst asserted during GO_LEFT -> state=000, all flags 0 next cycle.
